// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam int unsigned DEF_DEPTH = 256;
  localparam int unsigned AW        = 32;
  localparam int unsigned DW        = 32;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-requester winner selection: round-robin on ties, or fixed priority to port 0.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_served,
  input  logic       i_fixed,
  output logic       o_grant_valid_c,
  output logic       o_grant_idx_c
);

  always_comb begin
    o_grant_valid_c = |i_req;
    o_grant_idx_c   = i_req[0] ? PORT_CPU : PORT_LDR;
    // On a tie the port that was not served last goes next.
    if (&i_req) begin
      o_grant_idx_c = i_fixed ? PORT_CPU : ~i_last_served;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-ported DMEM between the CPU port (0) and the loader port (1),
// one registered access at a time with a one-cycle ack per access.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH          = DEF_DEPTH,
  parameter bit          FIXED_PRIORITY = 1'b0
) (
  input  logic          clk,
  input  logic          SYS_reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] DMEM_address,
  output logic [DW-1:0] DMEM_data_in,
  output logic          DMEM_mem_write,
  output logic          DMEM_mem_read,
  input  logic [DW-1:0] DMEM_data_out
);

  state_t        r_state, w_state_nxt;
  logic          r_owner, w_owner_nxt;
  logic          r_range_err, w_range_err_nxt;
  logic          r_last_served, w_last_served_nxt;
  logic [DW-1:0] r_rdata, w_rdata_nxt;
  logic          r_ack0, w_ack0_nxt;
  logic          r_ack1, w_ack1_nxt;
  logic          r_err0, w_err0_nxt;
  logic          r_err1, w_err1_nxt;
  logic          r_busy, w_busy_nxt;
  logic [AW-1:0] r_dmem_addr, w_dmem_addr_nxt;
  logic [DW-1:0] r_dmem_din, w_dmem_din_nxt;
  logic          r_dmem_wr, w_dmem_wr_nxt;
  logic          r_dmem_rd, w_dmem_rd_nxt;

  logic          w_grant_valid;
  logic          w_grant_idx;
  logic          w_sel_we;
  logic          w_sel_err;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  rr_pick2 u_pick (
    .i_req           ({req1, req0}),
    .i_last_served   (r_last_served),
    .i_fixed         (FIXED_PRIORITY),
    .o_grant_valid_c (w_grant_valid),
    .o_grant_idx_c   (w_grant_idx)
  );

  assign w_sel_we    = (w_grant_idx == PORT_LDR) ? we1    : we0;
  assign w_sel_addr  = (w_grant_idx == PORT_LDR) ? addr1  : addr0;
  assign w_sel_wdata = (w_grant_idx == PORT_LDR) ? wdata1 : wdata0;
  assign w_sel_err   = (w_sel_addr >= AW'(DEPTH));

  // Next-state and registered-output logic; DMEM drive is only non-zero for the ACCESS cycle.
  always_comb begin
    w_state_nxt       = r_state;
    w_owner_nxt       = r_owner;
    w_range_err_nxt   = r_range_err;
    w_last_served_nxt = r_last_served;
    w_rdata_nxt       = r_rdata;
    w_busy_nxt        = r_busy;
    w_ack0_nxt        = 1'b0;
    w_ack1_nxt        = 1'b0;
    w_err0_nxt        = 1'b0;
    w_err1_nxt        = 1'b0;
    w_dmem_addr_nxt   = '0;
    w_dmem_din_nxt    = '0;
    w_dmem_wr_nxt     = 1'b0;
    w_dmem_rd_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_owner_nxt       = w_grant_idx;
          w_last_served_nxt = w_grant_idx;
          w_range_err_nxt   = w_sel_err;
          w_dmem_addr_nxt   = w_sel_addr;
          w_dmem_din_nxt    = w_sel_wdata;
          w_dmem_wr_nxt     = w_sel_we & ~w_sel_err;
          w_dmem_rd_nxt     = ~w_sel_we & ~w_sel_err;
          w_busy_nxt        = 1'b1;
          w_state_nxt       = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_rdata_nxt = r_dmem_rd ? DMEM_data_out : '0;
        w_ack0_nxt  = (r_owner == PORT_CPU);
        w_ack1_nxt  = (r_owner == PORT_LDR);
        w_err0_nxt  = (r_owner == PORT_CPU) & r_range_err;
        w_err1_nxt  = (r_owner == PORT_LDR) & r_range_err;
        w_busy_nxt  = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (SYS_reset) begin
      r_state       <= ST_IDLE;
      r_owner       <= PORT_CPU;
      r_range_err   <= 1'b0;
      r_last_served <= PORT_LDR;
      r_rdata       <= '0;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_err0        <= 1'b0;
      r_err1        <= 1'b0;
      r_busy        <= 1'b0;
      r_dmem_addr   <= '0;
      r_dmem_din    <= '0;
      r_dmem_wr     <= 1'b0;
      r_dmem_rd     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_owner       <= w_owner_nxt;
      r_range_err   <= w_range_err_nxt;
      r_last_served <= w_last_served_nxt;
      r_rdata       <= w_rdata_nxt;
      r_ack0        <= w_ack0_nxt;
      r_ack1        <= w_ack1_nxt;
      r_err0        <= w_err0_nxt;
      r_err1        <= w_err1_nxt;
      r_busy        <= w_busy_nxt;
      r_dmem_addr   <= w_dmem_addr_nxt;
      r_dmem_din    <= w_dmem_din_nxt;
      r_dmem_wr     <= w_dmem_wr_nxt;
      r_dmem_rd     <= w_dmem_rd_nxt;
    end
  end

  assign ack0           = r_ack0;
  assign ack1           = r_ack1;
  assign err0           = r_err0;
  assign err1           = r_err1;
  assign rdata          = r_rdata;
  assign busy           = r_busy;
  assign DMEM_address   = r_dmem_addr;
  assign DMEM_data_in   = r_dmem_din;
  assign DMEM_mem_write = r_dmem_wr;
  assign DMEM_mem_read  = r_dmem_rd;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random two-port traffic, checked by a scoreboard.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        SYS_reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err0, err1, busy;
  logic [31:0] rdata, DMEM_address, DMEM_data_in, DMEM_data_out;
  logic        DMEM_mem_write, DMEM_mem_read;

  // Second instance with fixed priority, used only for the tie test.
  logic        f_req0 = 1'b0, f_req1 = 1'b0;
  logic [31:0] f_addr = 32'h4, f_zero = '0;
  logic        f_ack0, f_ack1, f_err0, f_err1, f_busy, f_dwr, f_drd;
  logic [31:0] f_rdata, f_daddr, f_din;

  int vectors = 0;
  int miscompares = 0;

  dmem_arbiter #(.DEPTH(256), .FIXED_PRIORITY(1'b0)) dut (
    .clk(clk), .SYS_reset(SYS_reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata(rdata), .busy(busy),
    .DMEM_address(DMEM_address), .DMEM_data_in(DMEM_data_in),
    .DMEM_mem_write(DMEM_mem_write), .DMEM_mem_read(DMEM_mem_read),
    .DMEM_data_out(DMEM_data_out)
  );

  dmem_arbiter #(.DEPTH(256), .FIXED_PRIORITY(1'b1)) u_fix (
    .clk(clk), .SYS_reset(SYS_reset),
    .req0(f_req0), .req1(f_req1), .we0(1'b0), .we1(1'b0),
    .addr0(f_addr), .addr1(f_addr), .wdata0(f_zero), .wdata1(f_zero),
    .ack0(f_ack0), .ack1(f_ack1), .err0(f_err0), .err1(f_err1),
    .rdata(f_rdata), .busy(f_busy),
    .DMEM_address(f_daddr), .DMEM_data_in(f_din),
    .DMEM_mem_write(f_dwr), .DMEM_mem_read(f_drd),
    .DMEM_data_out(f_zero)
  );

  function automatic logic [31:0] img(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0001;
  endfunction

  // DMEM: combinational read, write on falling edge, image reload on reset.
  logic [31:0] mem [256];
  assign DMEM_data_out = mem[DMEM_address[7:0]];
  always @(clk) begin
    if (clk && SYS_reset) begin
      for (int i = 0; i < 256; i++) mem[i] = img(i);
    end else if (!clk && DMEM_mem_write) begin
      mem[DMEM_address[7:0]] = DMEM_data_in;
    end
  end

  // Transaction-level reference: who is granted, when the ack is due, and what it returns.
  typedef struct {
    int          due;
    logic        port;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [256];
  int          cyc = 0;
  int          free_cyc = 0;
  logic        m_last = 1'b1;
  exp_t        m_e;
  logic        m_p, m_we;
  logic [31:0] m_a, m_d;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (SYS_reset) begin
      exp_q.delete();
      for (int i = 0; i < 256; i++) ref_mem[i] = img(i);
      free_cyc = cyc + 1;
      m_last   = 1'b1;
    end else if (cyc >= free_cyc && (req0 || req1)) begin
      if (req0 && req1) m_p = (m_last == 1'b1) ? 1'b0 : 1'b1;
      else              m_p = req1;
      m_a  = m_p ? addr1  : addr0;
      m_we = m_p ? we1    : we0;
      m_d  = m_p ? wdata1 : wdata0;
      m_e.due  = cyc + 1;
      m_e.port = m_p;
      m_e.err  = (m_a >= 32'd256);
      if (m_e.err) m_e.data = '0;
      else if (m_we) begin
        ref_mem[m_a[7:0]] = m_d;
        m_e.data = '0;
      end else m_e.data = ref_mem[m_a[7:0]];
      exp_q.push_back(m_e);
      m_last   = m_p;
      free_cyc = cyc + 3;
    end
  end

  // Monitor: every ack must match the head of the scoreboard in cycle, port, err and data.
  exp_t mon_e;
  always @(negedge clk) begin
    if (DMEM_mem_write || DMEM_mem_read) begin
      vectors++;
      if (DMEM_mem_write && DMEM_mem_read) begin
        miscompares++;
        $display("FAIL strobe_excl: both DMEM strobes high at cycle %0d", cyc);
      end
    end
    if (ack0 || ack1) begin
      vectors++;
      if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
        miscompares++;
        $display("FAIL unexpected_ack: cycle %0d ack0=%b ack1=%b, none due", cyc, ack0, ack1);
      end else begin
        mon_e = exp_q.pop_front();
        if (ack0 === ack1 || ack1 !== mon_e.port ||
            (mon_e.port ? err1 : err0) !== mon_e.err ||
            (mon_e.port ? err0 : err1) !== 1'b0 || rdata !== mon_e.data) begin
          miscompares++;
          $display("FAIL sb_ack: cycle %0d got ack0=%b ack1=%b err0=%b err1=%b rdata=%h, expected port %0d err %b rdata %h",
                   cyc, ack0, ack1, err0, err1, rdata, mon_e.port, mon_e.err, mon_e.data);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      vectors++;
      miscompares++;
      mon_e = exp_q.pop_front();
      $display("FAIL missing_ack: cycle %0d no ack, expected port %0d", cyc, mon_e.port);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_ctl"}, 32'({ack0, ack1, err0, err1, busy, DMEM_mem_write, DMEM_mem_read}), 32'h0);
    chk({name, "_rdata"}, rdata, 32'h0);
    chk({name, "_addr"}, DMEM_address, 32'h0);
    chk({name, "_din"}, DMEM_data_in, 32'h0);
  endtask

  task automatic drive_port(input bit p, input int n);
    bit          keep;
    int          t;
    logic [31:0] a;
    keep = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
      a = ($urandom_range(0, 7) == 0) ? (32'h100 | $urandom()) : 32'($urandom_range(0, 15));
      if (p) begin
        req1 = 1'b1; we1 = 1'($urandom_range(0, 1)); addr1 = a; wdata1 = $urandom();
      end else begin
        req0 = 1'b1; we0 = 1'($urandom_range(0, 1)); addr0 = a; wdata0 = $urandom();
      end
      t = 0;
      @(negedge clk);
      t++;
      while (!(p ? ack1 : ack0) && t < 40) begin
        @(negedge clk);
        t++;
      end
      if (t >= 40) begin
        vectors++;
        miscompares++;
        $display("FAIL ack_timeout: port %0d got no ack within %0d cycles", p, t);
      end
      keep = 1'($urandom_range(0, 1));
      if (!keep || k == n - 1) begin
        if (p) req1 = 1'b0; else req0 = 1'b0;
      end
    end
  endtask

  int   ord[$];
  int   exp_ord[4] = '{1, 0, 1, 0};
  int   f0_cnt, f1_cnt, b2b_cnt, b2b_dup;
  logic prev_ack;

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    SYS_reset = 1'b0;

    // Port 0 write 0xDEADBEEF @ 0x10
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_strobe", 32'({DMEM_mem_write, DMEM_mem_read}), 32'h2);
    chk("wr_addr", DMEM_address, 32'h10);
    chk("wr_data", DMEM_data_in, 32'hDEADBEEF);
    chk("wr_busy_noack", 32'({busy, ack0}), 32'h2);
    @(negedge clk);
    chk("wr_ack", 32'({ack0, err0, DMEM_mem_write}), 32'h4);
    req0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    chk("wr_busy_off", 32'(busy), 32'h0);

    // Port 1 reads it back
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h10;
    @(negedge clk);
    chk("rd_strobe", 32'({DMEM_mem_write, DMEM_mem_read}), 32'h1);
    chk("rd_addr", DMEM_address, 32'h10);
    @(negedge clk);
    chk("rd_ack", 32'({ack1, err1, DMEM_mem_read}), 32'h4);
    chk("rd_data", rdata, 32'hDEADBEEF);
    req1 = 1'b0;
    @(negedge clk);

    // Out-of-range read
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100;
    @(negedge clk);
    chk("oor_no_strobe", 32'({DMEM_mem_write, DMEM_mem_read}), 32'h0);
    @(negedge clk);
    chk("oor_ack_err", 32'({ack0, err0}), 32'h3);
    chk("oor_rdata", rdata, 32'h0);
    req0 = 1'b0;
    @(negedge clk);

    // Both ports hold reads for 12 cycles; port 0 was served last, so port 1 leads
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 32'h20; addr1 = 32'h30;
    f_req0 = 1'b1; f_req1 = 1'b1;
    f0_cnt = 0; f1_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ack0) ord.push_back(0);
      if (ack1) ord.push_back(1);
      if (f_ack0) f0_cnt++;
      if (f_ack1) f1_cnt++;
      if (i == 12) begin
        req0 = 1'b0; req1 = 1'b0; f_req0 = 1'b0; f_req1 = 1'b0;
      end
    end
    chk("rr_ack_count", 32'(ord.size()), 32'd4);
    if (ord.size() == 4)
      for (int i = 0; i < 4; i++) chk($sformatf("rr_order_%0d", i), 32'(ord[i]), 32'(exp_ord[i]));
    chk("fixed_ack0_count", 32'(f0_cnt), 32'd4);
    chk("fixed_ack1_count", 32'(f1_cnt), 32'd0);
    @(negedge clk);

    // Reset during the ACCESS cycle of a port 1 read
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
    @(negedge clk);
    chk("rst_in_access", 32'(DMEM_mem_read), 32'h1);
    SYS_reset = 1'b1; req1 = 1'b0;
    @(negedge clk);
    chk_idle_outputs("rst_abort");
    SYS_reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    @(negedge clk);
    chk("post_rst_noack", 32'(ack0), 32'h0);
    @(negedge clk);
    chk("post_rst_ack", 32'(ack0), 32'h1);
    chk("post_rst_data", rdata, img(16));
    req0 = 1'b0;
    @(negedge clk);

    // req0 held through its ack: one ack per 3 cycles, never on consecutive cycles
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h30;
    b2b_cnt = 0; b2b_dup = 0; prev_ack = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (ack0) b2b_cnt++;
      if (ack0 && prev_ack) b2b_dup++;
      prev_ack = ack0;
      if (i == 9) req0 = 1'b0;
    end
    chk("b2b_ack_count", 32'(b2b_cnt), 32'd3);
    chk("b2b_dup_ack", 32'(b2b_dup), 32'd0);
    repeat (2) @(negedge clk);

    // Random concurrent traffic on both ports
    fork
      drive_port(1'b0, 60);
      drive_port(1'b1, 60);
    join
    repeat (8) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
